// File: rtl/cycloneiiils_io_oserdes_pkg.sv
// cycloneiiils_io_oserdes_pkg: shared state encodings and parameter range checks for the output serializer
package cycloneiiils_io_oserdes_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    LAG   = 2'd3
  } state_t;
  function automatic bit cfg_ok(int width, int lead, int lag);
    return width >= 2 && width <= 32 && lead >= 0 && lead <= 15 && lag >= 0 && lag <= 15;
  endfunction
endpackage

// File: rtl/cycloneiiils_io_oserdes_if.sv
// cycloneiiils_io_oserdes_if: parallel word valid/ready handshake into the serializer
interface cycloneiiils_io_oserdes_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  modport master (output data_in, data_valid, input data_ready);
  modport slave  (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/cycloneiiils_io_shreg.sv
// cycloneiiils_io_shreg: load/shift register presenting the next serial bit; load and shift together drops the first bit
module cycloneiiils_io_shreg #(
  parameter int WIDTH = 8,
  parameter bit MSBF  = 1'b0
) (
  input  logic             clk,
  input  logic             sreset,
  input  logic             ena,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] d,
  output logic             q_first
);
  logic [WIDTH-1:0] q, base;
  always_comb begin
    base    = ld ? d : q;
    q_first = MSBF ? q[WIDTH-1] : q[0];
  end
  always_ff @(posedge clk) begin
    if (sreset) q <= '0;
    else if (ena && sh) q <= MSBF ? {base[WIDTH-2:0], 1'b0} : {1'b0, base[WIDTH-1:1]};
    else if (ena && ld) q <= d;
  end
endmodule

// File: rtl/cycloneiiils_io_oserdes.sv
// cycloneiiils_io_oserdes: valid/ready word serializer with programmable output-enable lead and lag
module cycloneiiils_io_oserdes
  import cycloneiiils_io_oserdes_pkg::*;
#(
  parameter int    WIDTH      = 8,
  parameter string MSB_FIRST  = "false",
  parameter int    OE_LEAD    = 1,
  parameter int    OE_LAG     = 1,
  parameter logic  IDLE_VALUE = 1'b0,
  parameter string lpm_type   = "cycloneiiils_io_oserdes"
) (
  input  logic clk,
  input  logic sreset,
  input  logic ena,
  cycloneiiils_io_oserdes_if.slave bus,
  output logic dataout,
  output logic oe_out,
  output logic busy
);
  localparam bit MSBF = MSB_FIRST == "true";
  localparam bit CFG_OK = cfg_ok(WIDTH, OE_LEAD, OE_LAG) && lpm_type == "cycloneiiils_io_oserdes";
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);
  state_t state;
  logic [BW-1:0] bcnt;
  logic [3:0] pcnt;
  logic acc, direct, sh, first_in, q_first;
  always_comb begin
    bus.data_ready = CFG_OK && ena && !sreset &&
                     (state == IDLE || state == LAG || (state == SHIFT && bcnt == '0));
    acc      = bus.data_valid && bus.data_ready;
    direct   = acc && (state != IDLE || OE_LEAD == 0);
    sh       = direct || (state == LEAD && pcnt == '0) || (state == SHIFT && bcnt != '0);
    first_in = MSBF ? bus.data_in[WIDTH-1] : bus.data_in[0];
  end
  cycloneiiils_io_shreg #(.WIDTH(WIDTH), .MSBF(MSBF)) u_shreg (
    .clk     (clk),
    .sreset  (sreset),
    .ena     (ena),
    .ld      (acc),
    .sh      (sh),
    .d       (bus.data_in),
    .q_first (q_first)
  );
  always_ff @(posedge clk) begin
    if (sreset) begin
      state   <= IDLE;
      bcnt    <= '0;
      pcnt    <= '0;
      dataout <= IDLE_VALUE;
      oe_out  <= 1'b0;
      busy    <= 1'b0;
    end else if (ena) begin
      if (direct) begin
        state   <= SHIFT;
        bcnt    <= BMAX;
        dataout <= first_in;
        oe_out  <= 1'b1;
        busy    <= 1'b1;
      end else if (acc) begin
        state   <= LEAD;
        pcnt    <= 4'(OE_LEAD - 1);
        dataout <= IDLE_VALUE;
        oe_out  <= 1'b1;
        busy    <= 1'b1;
      end else begin
        case (state)
          LEAD:
            if (pcnt == '0) begin
              state   <= SHIFT;
              bcnt    <= BMAX;
              dataout <= q_first;
            end else pcnt <= pcnt - 4'd1;
          SHIFT:
            if (bcnt != '0) begin
              bcnt    <= bcnt - 1'b1;
              dataout <= q_first;
            end else if (OE_LAG > 0) begin
              state   <= LAG;
              pcnt    <= 4'(OE_LAG - 1);
              dataout <= IDLE_VALUE;
            end else begin
              state   <= IDLE;
              dataout <= IDLE_VALUE;
              oe_out  <= 1'b0;
              busy    <= 1'b0;
            end
          LAG:
            if (pcnt == '0) begin
              state  <= IDLE;
              oe_out <= 1'b0;
              busy   <= 1'b0;
            end else pcnt <= pcnt - 4'd1;
          default: ;
        endcase
      end
    end
  end
endmodule
